// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Holds the controller state encoding and the byte-time arithmetic used by the timeout.
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    // One UART byte (start + 8 data + stop) spans 10 bit times of 4*CLK_DIV clocks.
    localparam int BYTE_CLKS_PER_DIV = 40;

    function automatic logic [31:0] timeout_clks(input int clk_div, input int bytes);
        return 32'(bytes * BYTE_CLKS_PER_DIV * clk_div);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: MAX_LEN x 8 register array, one synchronous write port
// and one asynchronous read port so the drain side sees data the cycle the pointer moves.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [7:0]       i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [7:0]       o_rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_wr_in_range;
    logic          w_rd_in_range;

    assign w_wr_idx      = i_wr_addr[AW-1:0];
    assign w_rd_idx      = i_rd_addr[AW-1:0];
    assign w_wr_in_range = (int'(i_wr_addr) < DEPTH);
    assign w_rd_in_range = (int'(i_rd_addr) < DEPTH);

    // Storage is pure data: the controller never reads an entry it has not written this frame.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = w_rd_in_range ? r_mem[w_rd_idx] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_rx byte stream as SYNC, LEN, payload, CHK; buffers the payload until the
// checksum passes, then drains it over a valid/ready stream. Bad, short or stalled frames are dropped.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int         CLK_DIV       = 108,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       frm_valid,
    input  logic       frm_ready,
    output logic [7:0] frm_data,
    output logic       frm_last,
    output logic       busy,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int          PTR_W     = $clog2(MAX_LEN + 1);
    localparam logic [31:0] TO_LIMIT  = timeout_clks(CLK_DIV, TIMEOUT_BYTES);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [7:0]       r_len;
    logic [7:0]       r_sum;
    logic [31:0]      r_to_cnt;
    logic             r_frm_valid;
    logic             r_err_chk;
    logic             r_err_len;
    logic             r_err_timeout;
    logic             r_err_overrun;

    logic             w_wr_en;
    logic [7:0]       w_rd_data;
    logic             w_len_ok;
    logic             w_chk_ok;
    logic             w_wr_last;
    logic             w_rd_last;
    logic             w_timeout;
    logic             w_handshake;
    logic             w_to_active;

    assign w_wr_en     = (r_state == ST_PAYLOAD) && rx_done;
    assign w_len_ok    = (rx_data != 8'h00) && (rx_data <= MAX_LEN_B);
    assign w_chk_ok    = (8'(r_sum + rx_data) == 8'h00);
    assign w_wr_last   = (8'(r_wr_ptr) == (r_len - 8'd1));
    assign w_rd_last   = (8'(r_rd_ptr) == (r_len - 8'd1));
    assign w_timeout   = (r_to_cnt == (TO_LIMIT - 32'd1));
    assign w_handshake = r_frm_valid && frm_ready;
    assign w_to_active = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .PTR_W (PTR_W)
    ) u_buf (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (rx_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_len         <= 8'h00;
            r_sum         <= 8'h00;
            r_to_cnt      <= 32'd0;
            r_frm_valid   <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;

            // Gap counter only runs while a frame is being received.
            if (rx_done || !w_to_active) begin
                r_to_cnt <= 32'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (rx_done && (rx_data == SYNC_BYTE)) begin
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_done) begin
                        r_len <= rx_data;
                        if (w_len_ok) begin
                            r_state  <= ST_PAYLOAD;
                            r_sum    <= rx_data;
                            r_wr_ptr <= '0;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_err_len <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state       <= ST_IDLE;
                        r_err_timeout <= 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_done) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_sum    <= r_sum + rx_data;
                        if (w_wr_last) begin
                            r_state <= ST_CHK;
                        end
                    end else if (w_timeout) begin
                        r_state       <= ST_IDLE;
                        r_err_timeout <= 1'b1;
                    end
                end
                ST_CHK: begin
                    if (rx_done) begin
                        if (w_chk_ok) begin
                            r_state     <= ST_DRAIN;
                            r_rd_ptr    <= '0;
                            r_frm_valid <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_err_chk <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state       <= ST_IDLE;
                        r_err_timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Incoming bytes cannot be buffered while the payload is still held.
                    if (rx_done) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (w_handshake) begin
                        if (w_rd_last) begin
                            r_state     <= ST_IDLE;
                            r_frm_valid <= 1'b0;
                            r_rd_ptr    <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign frm_valid   = r_frm_valid;
    assign frm_data    = r_frm_valid ? w_rd_data : 8'h00;
    assign frm_last    = r_frm_valid && w_rd_last;
    assign busy        = (r_state != ST_IDLE);
    assign err_chk     = r_err_chk;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames plus randomized frames checked
// against a frame-level reference model; a negedge monitor pops and compares every output event.
module tb_uart_rx_frame_ctrl;

    localparam int         TB_CLK_DIV  = 4;
    localparam int         TB_TO_BYTES = 2;
    localparam int         TB_MAX_LEN  = 16;
    localparam logic [7:0] TB_SYNC     = 8'hA5;
    localparam longint     TO_CLKS     = longint'(TB_TO_BYTES * 40 * TB_CLK_DIV);

    typedef enum int {E_CHK, E_LEN, E_TO, E_OVR} err_kind_t;
    typedef struct { logic [7:0] data; logic last; } exp_byte_t;
    typedef struct { err_kind_t kind; longint at; } exp_err_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frm_ready;
    logic       frm_valid;
    logic [7:0] frm_data;
    logic       frm_last;
    logic       busy;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;

    exp_byte_t  exp_bytes[$];
    exp_err_t   exp_errs[$];
    logic [7:0] pl_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    longint     cyc = 0;
    longint     t_last_rx = 0;
    int         ready_mode = 1;

    uart_rx_frame_ctrl #(
        .CLK_DIV       (TB_CLK_DIV),
        .SYNC_BYTE     (TB_SYNC),
        .MAX_LEN       (TB_MAX_LEN),
        .TIMEOUT_BYTES (TB_TO_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_data    (frm_data),
        .frm_last    (frm_last),
        .busy        (busy),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       frm_ready = 1'b0;
            1:       frm_ready = 1'b1;
            default: frm_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got_err(input err_kind_t k);
        exp_err_t e;
        if (exp_errs.size() == 0) begin
            check("unexpected_err_kind", longint'(k), -1);
        end else begin
            e = exp_errs.pop_front();
            check("err_kind", longint'(k), longint'(e.kind));
            if (e.at >= 0) check("err_timeout_latency", cyc, e.at);
        end
    endtask

    // Monitor: everything the DUT presents is compared against the scoreboard queues.
    logic       hold_act = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       busy_chk_pending = 1'b0;

    always @(negedge clk) begin
        exp_byte_t eb;
        int nerr;
        if (!rst_n) begin
            hold_act         = 1'b0;
            busy_chk_pending = 1'b0;
        end else begin
            if (busy_chk_pending) begin
                check("busy_after_last", longint'(busy), 0);
                check("valid_after_last", longint'(frm_valid), 0);
                busy_chk_pending = 1'b0;
            end
            if (hold_act && frm_valid) begin
                check("hold_data", longint'(frm_data), longint'(hold_data));
                check("hold_last", longint'(frm_last), longint'(hold_last));
            end
            if (frm_valid && frm_ready) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_byte", longint'(frm_data), -1);
                end else begin
                    eb = exp_bytes.pop_front();
                    check("frm_data", longint'(frm_data), longint'(eb.data));
                    check("frm_last", longint'(frm_last), longint'(eb.last));
                end
                if (frm_last) busy_chk_pending = 1'b1;
            end
            hold_act  = frm_valid && !frm_ready;
            hold_data = frm_data;
            hold_last = frm_last;
            nerr = int'(err_chk) + int'(err_len) + int'(err_timeout) + int'(err_overrun);
            if (nerr > 0) check("err_exclusive", longint'(nerr), 1);
            if (err_chk)     got_err(E_CHK);
            if (err_len)     got_err(E_LEN);
            if (err_timeout) got_err(E_TO);
            if (err_overrun) got_err(E_OVR);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        t_last_rx = cyc;
        rx_done   = 1'b0;
    endtask

    // Reference model: decides a frame's outcome from length rule and modular sum alone.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] chk);
        int s;
        if (len == 8'd0 || int'(len) > TB_MAX_LEN) begin
            exp_errs.push_back('{E_LEN, -1});
            send_byte(TB_SYNC, $urandom_range(1, 6));
            send_byte(len, $urandom_range(1, 6));
            return;
        end
        s = int'(len) + int'(chk);
        foreach (pl_q[i]) s += int'(pl_q[i]);
        if (s % 256 == 0) begin
            foreach (pl_q[i]) exp_bytes.push_back('{pl_q[i], (i == pl_q.size() - 1)});
        end else begin
            exp_errs.push_back('{E_CHK, -1});
        end
        send_byte(TB_SYNC, $urandom_range(1, 6));
        send_byte(len, $urandom_range(1, 6));
        foreach (pl_q[i]) send_byte(pl_q[i], $urandom_range(1, 6));
        send_byte(chk, $urandom_range(1, 6));
    endtask

    function automatic logic [7:0] good_chk(input logic [7:0] len);
        int s;
        s = int'(len);
        foreach (pl_q[i]) s += int'(pl_q[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check(name, longint'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, longint'(frm_valid), 0);
        check({tag, "_data"},  longint'(frm_data), 0);
        check({tag, "_last"},  longint'(frm_last), 0);
        check({tag, "_busy"},  longint'(busy), 0);
        check({tag, "_errs"},  longint'({err_chk, err_len, err_timeout, err_overrun}), 0);
    endtask

    initial begin
        logic [7:0] len;
        logic [7:0] b;
        int kind;

        frm_ready = 1'b1;
        #2 rst_n = 1'b0;
        #13 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Good two-byte frame
        ready_mode = 1;
        pl_q = '{8'h11, 8'h22};
        send_frame(8'h02, 8'hCB);
        wait_idle("idle_good", 200);

        // Checksum error
        pl_q = '{8'h11, 8'h22};
        send_frame(8'h02, 8'hCC);
        wait_idle("idle_badchk", 200);

        // Length errors
        pl_q.delete();
        send_frame(8'h00, 8'h00);
        wait_idle("idle_len0", 200);
        send_frame(8'h11, 8'h00);
        wait_idle("idle_len17", 200);

        // Inter-byte timeout measured from the last accepted byte
        send_byte(TB_SYNC, 2);
        send_byte(8'h03, 2);
        send_byte(8'h01, 2);
        exp_errs.push_back('{E_TO, t_last_rx + TO_CLKS});
        wait_idle("idle_timeout", int'(TO_CLKS) + 50);

        // Stalled drain with an overrun byte
        ready_mode = 0;
        pl_q = '{8'h11, 8'h22};
        send_frame(8'h02, 8'hCB);
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge clk);
            check("stall_valid", longint'(frm_valid), 1);
            check("stall_data", longint'(frm_data), 8'h11);
            check("stall_last", longint'(frm_last), 0);
        end
        exp_errs.push_back('{E_OVR, -1});
        send_byte(TB_SYNC, 0);
        repeat (3) @(posedge clk);
        ready_mode = 1;
        wait_idle("idle_overrun", 200);

        // Reset in the middle of a payload
        send_byte(TB_SYNC, 1);
        send_byte(8'h03, 1);
        send_byte(8'h11, 1);
        check("mid_payload_busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1 check_zero("rst_payload");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a drain
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send_byte(TB_SYNC, 1);
        send_byte(8'h02, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'hCB, 1);
        repeat (3) @(negedge clk);
        check("mid_drain_valid", longint'(frm_valid), 1);
        check("mid_drain_data", longint'(frm_data), 8'h11);
        #1 rst_n = 1'b0;
        #1 check_zero("rst_drain");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode = 1;
        pl_q = '{8'h5A, 8'hA5, 8'h3C};
        send_frame(8'h03, good_chk(8'h03));
        wait_idle("idle_after_rst", 200);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            ready_mode = $urandom_range(1, 2);
            for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
                b = 8'($urandom);
                if (b == TB_SYNC) b = 8'h5A;
                send_byte(b, $urandom_range(1, 4));
            end
            kind = $urandom_range(0, 3);
            pl_q.delete();
            if (kind == 3) begin
                len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(TB_MAX_LEN + 1, 255));
                send_frame(len, 8'h00);
            end else begin
                len = 8'($urandom_range(1, TB_MAX_LEN));
                for (int i = 0; i < int'(len); i++) pl_q.push_back(8'($urandom));
                if (kind == 2) send_frame(len, good_chk(len) ^ 8'($urandom_range(1, 255)));
                else           send_frame(len, good_chk(len));
            end
            wait_idle("idle_random", 3000);
        end

        repeat (10) @(posedge clk);
        check("bytes_left", longint'(exp_bytes.size()), 0);
        check("errs_left", longint'(exp_errs.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
